// File: rtl/servo_pkg.sv
// Shared types and helpers for the ramped servo controller and the sonar timing logic.
package servo_pkg;

    typedef enum logic [1:0] {
        PARADO   = 2'b00,
        MOVENDO  = 2'b01,
        SUSPENSO = 2'b10
    } estado_t;

    // Default timing for a 50 MHz clock: 20 ms period, 1..2 ms pulse.
    localparam int PERIODO_PADRAO  = 1_000_000;
    localparam int LARG_MIN_PADRAO = 50_000;
    localparam int LARG_MAX_PADRAO = 100_000;
    localparam int N_POS_PADRAO    = 3;
    localparam int PASSO_PADRAO    = 2_500;

    function automatic int calc_alvo(int posicao, int larg_min, int larg_max, int n_pos);
        int delta;
        int alvo;
        delta = (larg_max - larg_min) / ((1 << n_pos) - 1);
        alvo  = larg_min + posicao * delta;
        return (alvo > larg_max) ? larg_max : alvo;
    endfunction

endpackage

// File: rtl/controle_servo_rampa_if.sv
// Link between the sonar sweep FSM (master) and the servo controller (slave).
interface controle_servo_rampa_if #(
    parameter int N_POS = 3
);
    logic [N_POS-1:0] posicao;
    logic             atualiza;
    logic             habilita;
    logic             pronto;

    modport master (output posicao, output atualiza, output habilita, input pronto);
    modport slave  (input posicao, input atualiza, input habilita, output pronto);
endinterface

// File: rtl/contador_periodo.sv
// Free-running 0..PERIODO-1 counter with a registered tick aligned to the last count.
module contador_periodo #(
    parameter  int PERIODO = 1_000_000,
    localparam int CW      = $clog2(PERIODO)
) (
    input  logic          clock,
    input  logic          reset,
    output logic [CW-1:0] contador,
    output logic          fim_periodo
);

    // NOTE: sequential state uses <= so every register samples pre-edge values; = here would race.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contador    <= '0;
            fim_periodo <= 1'b0;
        end else begin
            contador    <= (contador == CW'(PERIODO - 1)) ? '0 : contador + CW'(1);
            // Decoded one count early so the registered tick is high while contador==PERIODO-1.
            fim_periodo <= (contador == CW'(PERIODO - 2));
        end
    end

endmodule

// File: rtl/controle_servo_rampa.sv
// Servo PWM with linear position mapping and per-period slew limiting toward the target width.
module controle_servo_rampa
    import servo_pkg::*;
#(
    parameter  int PERIODO  = PERIODO_PADRAO,
    parameter  int LARG_MIN = LARG_MIN_PADRAO,
    parameter  int LARG_MAX = LARG_MAX_PADRAO,
    parameter  int N_POS    = N_POS_PADRAO,
    parameter  int PASSO    = PASSO_PADRAO,
    localparam int W        = $clog2(LARG_MAX + 1),
    localparam int CW       = $clog2(PERIODO)
) (
    input  logic                   clock,
    input  logic                   reset,
    controle_servo_rampa_if.slave  bus,
    output logic                   controle,
    output logic                   db_controle,
    output logic [W-1:0]           largura_atual,
    output logic [1:0]             db_estado
);

    // Only used when the remaining distance exceeds PASSO, so it always fits in W bits.
    localparam logic [W-1:0] PASSO_W = W'(PASSO);

    logic [CW-1:0] contador;
    logic          fim_periodo;
    logic [W-1:0]  alvo_reg;
    logic [W-1:0]  alvo_novo;
    logic [W-1:0]  diferenca;
    logic          iguais;
    logic          subir;
    logic          perto;
    logic          pronto;
    estado_t       estado;
    estado_t       estado_prox;

    contador_periodo #(.PERIODO(PERIODO)) u_contador (
        .clock       (clock),
        .reset       (reset),
        .contador    (contador),
        .fim_periodo (fim_periodo)
    );

    assign alvo_novo = W'(calc_alvo(int'(bus.posicao), LARG_MIN, LARG_MAX, N_POS));
    assign iguais    = (alvo_reg == largura_atual);
    assign subir     = (alvo_reg > largura_atual);
    assign diferenca = subir ? (alvo_reg - largura_atual) : (largura_atual - alvo_reg);
    assign perto     = (32'(diferenca) <= 32'(PASSO));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= PARADO;
        end else begin
            estado <= estado_prox;
        end
    end

    always_comb begin
        // NOTE: default first, so no path through the case leaves estado_prox unassigned (latch).
        estado_prox = estado;
        if (!bus.habilita) begin
            estado_prox = SUSPENSO;
        end else begin
            case (estado)
                PARADO:   if (!iguais) estado_prox = MOVENDO;
                MOVENDO:  if (fim_periodo && perto) estado_prox = PARADO;
                SUSPENSO: estado_prox = iguais ? PARADO : MOVENDO;
                default:  estado_prox = PARADO;
            endcase
        end
    end

    always_comb begin
        pronto = 1'b0;
        case (estado)
            PARADO:   pronto = 1'b1;
            SUSPENSO: pronto = iguais;
            default:  pronto = 1'b0;
        endcase
    end

    assign bus.pronto  = pronto;
    assign db_estado   = estado;
    assign db_controle = controle;

    // Width moves only at the period boundary, so each pulse is generated whole with one width.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            alvo_reg      <= W'(LARG_MIN);
            largura_atual <= W'(LARG_MIN);
            controle      <= 1'b0;
        end else begin
            if (bus.atualiza) begin
                alvo_reg <= alvo_novo;
            end
            if (estado == MOVENDO && bus.habilita && fim_periodo) begin
                if (perto) begin
                    largura_atual <= alvo_reg;
                end else if (subir) begin
                    largura_atual <= largura_atual + PASSO_W;
                end else begin
                    largura_atual <= largura_atual - PASSO_W;
                end
            end
            controle <= bus.habilita & (32'(contador) < 32'(largura_atual));
        end
    end

endmodule
